// File: rtl/id_ex_elastic_stage.sv
// ID->EX pipeline stage with valid/ready handshake and a 2-entry skid buffer.
// Immediate is extended at capture; control is forced to zero on bubbles.
module id_ex_elastic_stage #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic              in_imm_zext,
  input  logic [REG_W-1:0]  in_rs,
  input  logic [REG_W-1:0]  in_rt,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rs_data,
  output logic [DATA_W-1:0] out_rt_data,
  output logic [DATA_W-1:0] out_imm,
  output logic [REG_W-1:0]  out_rs,
  output logic [REG_W-1:0]  out_rt,
  output logic [REG_W-1:0]  out_rd,
  output logic [CTRL_W-1:0] out_ctrl
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  typedef struct packed {
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [CTRL_W-1:0] ctrl;
  } beat_t;

  logic [1:0] state_q, state_d;
  beat_t      main_q, main_d;
  beat_t      skid_q, skid_d;
  beat_t      in_beat;
  logic       acc, pop;

  always_comb begin
    in_beat.rs_data = in_rs_data;
    in_beat.rt_data = in_rt_data;
    in_beat.imm     = {{(DATA_W-IMM_W){in_imm_zext ? 1'b0 : in_imm[IMM_W-1]}},
                       in_imm};
    in_beat.rs      = in_rs;
    in_beat.rt      = in_rt;
    in_beat.rd      = in_rd;
    in_beat.ctrl    = in_ctrl;
  end

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign acc       = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (acc) begin
            main_d  = in_beat;
            state_d = ONE;
          end
        end
        ONE: begin
          if (acc && pop) begin
            main_d = in_beat;
          end else if (acc) begin
            skid_d  = in_beat;
            state_d = TWO;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Bubbles present a NOP even to consumers that ignore out_valid.
  assign out_ctrl    = out_valid ? main_q.ctrl : '0;
  assign out_rs_data = main_q.rs_data;
  assign out_rt_data = main_q.rt_data;
  assign out_imm     = main_q.imm;
  assign out_rs      = main_q.rs;
  assign out_rt      = main_q.rt;
  assign out_rd      = main_q.rd;

endmodule
